// File: rtl/lns_mul_stage.sv
// lns_mul_stage: two-stage LNS multiply front-end feeding the LNS adder over valid/ready.
// Optional sticky overflow/underflow flags are enabled by defining LNS_MUL_FLAGS_EN.
module lns_mul_stage #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_p,
    output logic [WIDTH-1:0] out_c,
`ifdef LNS_MUL_FLAGS_EN
    input  logic             clr_flags,
`endif
    output logic             ovf_flag,
    output logic             unf_flag
);
    localparam logic signed [WIDTH-1:0] LMAX = WIDTH'(2 ** (WIDTH - 2) - 1);
    localparam logic signed [WIDTH-1:0] LMIN = ~LMAX;
    localparam logic [WIDTH-1:0] ZCODE = {2'b01, {(WIDTH - 2){1'b0}}};

    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic             s1_sign_q, s1_zero_q, s1_zero_d;
    logic [WIDTH-1:0] s1_sum_q, s1_sum_d, s1_c_q, p_q, p_d, c_q;
    logic             in_xfer, out_xfer, s1_adv, ovf_ev, unf_ev;

    assign out_xfer  = s2_v_q && out_ready;
    assign s1_adv    = s1_v_q && (!s2_v_q || out_xfer);
    assign in_ready  = !s1_v_q || s1_adv;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = s2_v_q;
    assign out_p     = p_q;
    assign out_c     = c_q;

    always_comb begin
        s1_v_d    = in_xfer ? 1'b1 : (s1_adv ? 1'b0 : s1_v_q);
        s2_v_d    = s1_adv ? 1'b1 : (out_xfer ? 1'b0 : s2_v_q);
        s1_sum_d  = {in_a[WIDTH-2], in_a[WIDTH-2:0]} + {in_b[WIDTH-2], in_b[WIDTH-2:0]};
        s1_zero_d = (in_a[WIDTH-2:0] == ZCODE[WIDTH-2:0]) || (in_b[WIDTH-2:0] == ZCODE[WIDTH-2:0]);
        // Zero operands bypass classification so they never raise an event.
        ovf_ev    = !s1_zero_q && ($signed(s1_sum_q) > LMAX);
        unf_ev    = !s1_zero_q && ($signed(s1_sum_q) <= LMIN);
        p_d       = (s1_zero_q || unf_ev) ? ZCODE :
                    ovf_ev ? {s1_sign_q, LMAX[WIDTH-2:0]} : {s1_sign_q, s1_sum_q[WIDTH-2:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_sum_q  <= '0;
            s1_c_q    <= '0;
            p_q       <= '0;
            c_q       <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (in_xfer) begin
                s1_sign_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
                s1_zero_q <= s1_zero_d;
                s1_sum_q  <= s1_sum_d;
                s1_c_q    <= in_c;
            end
            if (s1_adv) begin
                p_q <= p_d;
                c_q <= s1_c_q;
            end
        end
    end

`ifdef LNS_MUL_FLAGS_EN
    logic ovf_q, unf_q;

    // A new event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (s1_adv && ovf_ev) || (ovf_q && !clr_flags);
            unf_q <= (s1_adv && unf_ev) || (unf_q && !clr_flags);
        end
    end

    assign ovf_flag = ovf_q;
    assign unf_flag = unf_q;
`else
    assign ovf_flag = 1'b0;
    assign unf_flag = 1'b0;
`endif
endmodule

// File: tb/tb_lns_mul_stage.sv
// tb_lns_mul_stage: randomized scoreboard bench for lns_mul_stage with directed corner cases.
// Flag expectations follow LNS_MUL_FLAGS_EN when it is defined.
module tb_lns_mul_stage;
    localparam int W = 12;
    localparam int HALF = 1 << (W - 2);

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, in_c = '0;
    logic in_ready, out_valid, ovf_flag, unf_flag;
    logic [W-1:0] out_p, out_c;
`ifdef LNS_MUL_FLAGS_EN
    logic clr_flags = 1'b0;
`endif

    int checks = 0, errors = 0, pops = 0;
    logic [2*W+1:0] sbq[$];
    logic held = 1'b0, saw_block = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    logic [W-1:0] hp = '0, hc = '0;

    lns_mul_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_c(out_c),
`ifdef LNS_MUL_FLAGS_EN
        .clr_flags(clr_flags),
`endif
        .ovf_flag(ovf_flag), .unf_flag(unf_flag)
    );

    always #5 clk = ~clk;

    // Reference: real log sums with integer arithmetic, then classify.
    function automatic logic [2*W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        int la, lb, s;
        logic sg, ov, un;
        logic [W-1:0] p;
        la = int'(a[W-2:0]);
        lb = int'(b[W-2:0]);
        if (la >= HALF) la -= 2 * HALF;
        if (lb >= HALF) lb -= 2 * HALF;
        s = la + lb;
        sg = a[W-1] ^ b[W-1];
        ov = 1'b0;
        un = 1'b0;
        if (la == -HALF || lb == -HALF) p = W'(HALF);
        else if (s > HALF - 1) begin p = {sg, (W-1)'(HALF - 1)}; ov = 1'b1; end
        else if (s <= -HALF) begin p = W'(HALF); un = 1'b1; end
        else p = {sg, (W-1)'(s)};
        return {ov, un, p, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [2*W+1:0] e;
        if (rst) begin
            sbq.delete();
            held = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (held) chk("stall_hold", {out_valid, out_p, out_c}, {1'b1, hp, hc});
            held = out_valid && !out_ready;
            hp = out_p;
            hc = out_c;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) sbq.push_back(model(in_a, in_b, in_c));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got p=%0h c=%0h expected none", out_p, out_c);
                end else begin
                    e = sbq.pop_front();
                    pops++;
`ifdef LNS_MUL_FLAGS_EN
                    m_ovf = m_ovf | e[2*W+1];
                    m_unf = m_unf | e[2*W];
`endif
                    chk("out_p", out_p, e[2*W-1:W]);
                    chk("out_c", out_c, e[W-1:0]);
                    chk("ovf_flag", ovf_flag, m_ovf);
                    chk("unf_flag", unf_flag, m_unf);
                end
            end
`ifdef LNS_MUL_FLAGS_EN
            if (clr_flags) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
`endif
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        in_a = a;
        in_b = b;
        in_c = c;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] exp);
        out_ready = 1'b1;
        send(a, b, c);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk({name, "_lat1"}, out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk({name, "_lat2"}, out_valid, 1'b1);
        chk(name, out_p, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sbq.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain", sbq.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        v = W'($urandom);
        case ($urandom_range(0, 5))
            0: v[W-2:0] = (W-1)'(HALF);
            1: v[W-2:W-3] = 2'b01;
            2: v[W-2:W-3] = 2'b10;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_flags", {ovf_flag, unf_flag}, 2'b00);
        @(posedge clk);
        #1;
        one("basic", 12'h010, 12'h820, 12'h123, 12'h830);
        chk("basic_flags", {ovf_flag, unf_flag}, 2'b00);
        one("overflow", 12'h300, 12'h200, 12'h0AA, 12'h3FF);
`ifdef LNS_MUL_FLAGS_EN
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_sticky", ovf_flag, 1'b1);
        clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
        chk("ovf_cleared", ovf_flag, 1'b0);
`else
        chk("ovf_absent", ovf_flag, 1'b0);
`endif
        one("underflow", 12'h500, 12'h600, 12'h055, 12'h400);
`ifdef LNS_MUL_FLAGS_EN
        chk("unf_set", unf_flag, 1'b1);
        clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
`else
        chk("unf_absent", unf_flag, 1'b0);
`endif
        one("near_min", 12'h600, 12'h601, 12'h001, 12'h401);
        chk("near_min_flags", {ovf_flag, unf_flag}, 2'b00);
        one("zero", 12'h400, 12'h8FF, 12'h002, 12'h400);
        chk("zero_flags", {ovf_flag, unf_flag}, 2'b00);

        saw_block = 1'b0;
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 5; i++) send(pick(), pick(), W'(i + 16));
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_blocked", saw_block, 1'b1);
        chk("bp_count", pops - p0, 5);

        fork
            begin
                repeat (400) begin
                    send(pick(), pick(), W'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                repeat (1500) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(12'h300, 12'h200, 12'h111);
        send(12'h010, 12'h020, 12'h222);
        in_valid = 1'b0;
        p0 = pops;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_flags", {ovf_flag, unf_flag}, 2'b00);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_flushed", pops - p0, 0);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
